// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings and helpers for the calculator result display path
package calc_pkg;
  localparam int RES_W = 8;
  localparam int NDIG  = 3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [9:0][6:0] SEG_DIGIT = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                           7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  // Double-dabble correction applied before each left shift
  function automatic logic [NDIG*4-1:0] dd_adjust(input logic [NDIG*4-1:0] b);
    logic [NDIG*4-1:0] r;
    for (int i = 0; i < NDIG; i++)
      r[i*4+:4] = b[i*4+:4] >= 4'd5 ? b[i*4+:4] + 4'd3 : b[i*4+:4];
    return r;
  endfunction
endpackage

// File: rtl/calc_result_display_if.sv
// calc_result_display_if: result handshake and display pins of the result display
interface calc_result_display_if;
  import calc_pkg::*;
  logic [RES_W-1:0]  res;
  logic              sign;
  logic              load;
  logic              busy;
  logic              done;
  logic [NDIG*4-1:0] digits;
  logic              neg;
  logic [6:0]        seg;
  logic [3:0]        an;
  modport master (output res, sign, load, input busy, done, digits, neg, seg, an);
  modport slave  (input res, sign, load, output busy, done, digits, neg, seg, an);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high {g,f,e,d,c,b,a} pattern with blanking
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  assign seg_o = (blank_i || bcd_i > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd_i];
endmodule

// File: rtl/calc_result_display.sv
// calc_result_display: sample result, convert to BCD by double-dabble, scan a 4-digit display
module calc_result_display
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic clk,
  input logic rst_n,
  calc_result_display_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  logic [1:0]        state_q, state_d;
  logic [RES_W-1:0]  bin_q, bin_d;
  logic [NDIG*4-1:0] bcd_q, bcd_d, adj;
  logic [2:0]        cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [NDIG*4-1:0] digits_q, digits_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        seg_q, seg_d, dec_seg;
  logic [3:0]        an_q, an_d;
  logic [3:0]        nib;
  logic              blank;
  always_comb begin
    adj      = dd_adjust(bcd_q);
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    digits_d = digits_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    if (state_q == ST_IDLE && bus.load) begin
      bin_d   = bus.res;
      sign_d  = bus.sign;
      bcd_d   = '0;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d   = cnt_q + 3'd1;
      state_d = cnt_q == 3'd7 ? ST_LATCH : ST_SHIFT;
    end else if (state_q == ST_LATCH) begin
      digits_d = bcd_q;
      neg_d    = sign_q;
      done_d   = 1'b1;
      state_d  = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end
  // Leading-zero suppression: units always shown, tens only blank when hundreds is too
  always_comb begin
    pre_d = pre_q == PRE_LAST ? '0 : pre_q + 1'b1;
    idx_d = pre_q == PRE_LAST ? idx_q + 2'd1 : idx_q;
    nib   = idx_q == 2'd2 ? digits_q[11:8] : idx_q == 2'd1 ? digits_q[7:4] : digits_q[3:0];
    blank = idx_q == 2'd2 ? digits_q[11:8] == 4'd0 :
            idx_q == 2'd1 ? digits_q[11:4] == 8'd0 : 1'b0;
    seg_d = idx_q == 2'd3 ? (neg_q ? SEG_MINUS : SEG_BLANK) : dec_seg;
    an_d  = ~(4'b0001 << idx_q);
  end
  seg7_decode u_dec (.bcd_i(nib), .blank_i(blank), .seg_o(dec_seg));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_DIGIT[0];
      an_q     <= 4'b1110;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      digits_q <= digits_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end
  assign bus.busy   = state_q != ST_IDLE;
  assign bus.done   = done_q;
  assign bus.digits = digits_q;
  assign bus.neg    = neg_q;
  assign bus.seg    = seg_q;
  assign bus.an     = an_q;
endmodule

// File: tb/tb_calc_result_display.sv
// tb_calc_result_display: randomized and directed checks against a decimal display model
module tb_calc_result_display;
  localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int m_t = 0;
  int m_val = 0;
  bit m_neg = 0;
  int m_left = 0;
  int p_val = 0;
  bit p_sign = 0;
  calc_result_display_if bus ();
  calc_result_display #(.REFRESH_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    else n_pass++;
  endtask
  function automatic logic [6:0] disp(int idx, int v, bit ng);
    return idx == 3 ? (ng ? 7'h40 : 7'h00) :
           idx == 2 ? (v >= 100 ? SEGTAB[v / 100] : 7'h00) :
           idx == 1 ? (v >= 10 ? SEGTAB[(v / 10) % 10] : 7'h00) : SEGTAB[v % 10];
  endfunction
  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic tick(input logic ld, input logic [7:0] r, input logic s);
    int old_idx, old_val;
    bit old_neg, e_done;
    bus.load = ld;
    bus.res  = r;
    bus.sign = s;
    @(posedge clk);
    old_idx = (m_t / 4) % 4;
    old_val = m_val;
    old_neg = m_neg;
    m_t++;
    e_done = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_val  = p_val;
        m_neg  = p_sign;
        e_done = 1;
      end
    end else if (ld) begin
      p_val  = int'(r);
      p_sign = s;
      m_left = 9;
    end
    @(negedge clk);
    check("busy", 32'(bus.busy), 32'(m_left > 0));
    check("done", 32'(bus.done), 32'(e_done));
    check("digits", 32'(bus.digits), 32'(to_bcd(m_val)));
    check("neg", 32'(bus.neg), 32'(m_neg));
    check("seg", 32'(bus.seg), 32'(disp(old_idx, old_val, old_neg)));
    check("an", 32'(bus.an), 32'(4'hF & ~(4'b0001 << old_idx)));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'($urandom));
  endtask
  task automatic reset_values(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_done"}, 32'(bus.done), 32'(0));
    check({tag, "_digits"}, 32'(bus.digits), 32'(0));
    check({tag, "_neg"}, 32'(bus.neg), 32'(0));
    check({tag, "_an"}, 32'(bus.an), 32'(4'b1110));
    check({tag, "_seg"}, 32'(bus.seg), 32'(7'b0111111));
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 reset_values("rst_async");
    m_t = 0;
    m_val = 0;
    m_neg = 0;
    m_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.load = 1'b0;
    bus.res  = '0;
    bus.sign = 1'b0;
    @(negedge clk);
    reset_values("rst_init");
    rst_n = 1'b1;
    tick(1'b1, 8'd255, 1'b0);
    idle(30);
    tick(1'b1, 8'd7, 1'b1);
    idle(26);
    tick(1'b1, 8'd105, 1'b0);
    idle(26);
    tick(1'b1, 8'd0, 1'b1);
    idle(26);
    tick(1'b1, 8'd200, 1'b0);
    idle(3);
    tick(1'b1, 8'd3, 1'b0);
    idle(5);
    tick(1'b1, 8'd3, 1'b0);
    idle(20);
    tick(1'b1, 8'd42, 1'b0);
    idle(12);
    tick(1'b1, 8'd99, 1'b0);
    idle(4);
    do_reset();
    idle(2);
    tick(1'b1, 8'd99, 1'b0);
    idle(20);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      tick($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
